// File: rtl/symbol_timing_ctrl_pkg.sv
// Shared types, widths and the control-word saturation helper for the symbol timing slice.
package timing_ctrl_pkg;

  localparam int CTRL_W = 32;
  localparam int ACC_W  = 34;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2
  } state_e;

  function automatic logic signed [CTRL_W-1:0] sat_ctrl(
    input logic signed [ACC_W-1:0] val,
    input logic signed [ACC_W-1:0] lim
  );
    logic signed [ACC_W-1:0] res;
    if (val > lim) begin
      res = lim;
    end else if (val < -lim) begin
      res = -lim;
    end else begin
      res = val;
    end
    return res[CTRL_W-1:0];
  endfunction

endpackage

// File: rtl/symbol_timing_ctrl_if.sv
// Sample/TED inputs and interpolation strobe outputs of the timing scheduler.
interface symbol_timing_ctrl_if #(
  parameter int MU_W = 8
);
  import timing_ctrl_pkg::*;

  logic                     sample_valid;
  logic signed [CTRL_W-1:0] ted_er;
  logic                     ted_valid;
  logic                     interp_strobe;
  logic [MU_W-1:0]          interp_mu;
  logic                     strobe_is_symbol;

  modport master (
    output sample_valid, ted_er, ted_valid,
    input  interp_strobe, interp_mu, strobe_is_symbol
  );

  modport slave (
    input  sample_valid, ted_er, ted_valid,
    output interp_strobe, interp_mu, strobe_is_symbol
  );

endinterface

// File: rtl/symbol_timing_ctrl_loop_filter.sv
// PI loop filter for the TED error; integrator and output both saturate at +/-CTRL_MAX.
module timing_loop_filter
  import timing_ctrl_pkg::*;
#(
  parameter logic [CTRL_W-1:0] CTRL_MAX = 32'h2000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [CTRL_W-1:0] er,
  input  logic [4:0]               kp_shift,
  input  logic [4:0]               ki_shift,
  output logic signed [CTRL_W-1:0] ctrl
);

  localparam logic signed [ACC_W-1:0] LIM = $signed({2'b00, CTRL_MAX});

  logic signed [CTRL_W-1:0] integ_r, ctrl_r;
  logic signed [CTRL_W-1:0] integ_new_s, ctrl_new_s;
  logic signed [ACC_W-1:0]  er_ext_s, integ_ext_s, integ_new_ext_s;
  logic signed [ACC_W-1:0]  ki_term_s, kp_term_s, integ_sum_s, ctrl_sum_s;

  // Each term lives in its own signed variable so the shifts stay arithmetic.
  always_comb begin
    er_ext_s        = {{(ACC_W-CTRL_W){er[CTRL_W-1]}}, er};
    integ_ext_s     = {{(ACC_W-CTRL_W){integ_r[CTRL_W-1]}}, integ_r};
    ki_term_s       = er_ext_s >>> ki_shift;
    kp_term_s       = er_ext_s >>> kp_shift;
    integ_sum_s     = integ_ext_s + ki_term_s;
    integ_new_s     = sat_ctrl(integ_sum_s, LIM);
    integ_new_ext_s = {{(ACC_W-CTRL_W){integ_new_s[CTRL_W-1]}}, integ_new_s};
    ctrl_sum_s      = integ_new_ext_s + kp_term_s;
    ctrl_new_s      = sat_ctrl(ctrl_sum_s, LIM);
  end

  // Integrator and control word registers.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      integ_r <= 32'sd0;
      ctrl_r  <= 32'sd0;
    end else if (en) begin
      integ_r <= integ_new_s;
      ctrl_r  <= ctrl_new_s;
    end
  end

  assign ctrl = ctrl_r;

endmodule

// File: rtl/symbol_timing_ctrl.sv
// Symbol timing scheduler: NCO-driven interpolation strobes, PI step correction and lock tracking.
module symbol_timing_ctrl
  import timing_ctrl_pkg::*;
#(
  parameter int                MU_W       = 8,
  parameter logic [CTRL_W-1:0] CTRL_MAX   = 32'h2000_0000,
  parameter logic [CTRL_W-1:0] LOCK_THR   = 32'h0000_4000,
  parameter int                LOCK_CNT   = 16,
  parameter int                UNLOCK_CNT = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [31:0]              cfg_nom_step,
  input  logic [4:0]               cfg_kp_shift,
  input  logic [4:0]               cfg_ki_shift,
  symbol_timing_ctrl_if.slave      bus,
  output logic signed [CTRL_W-1:0] loop_ctrl,
  output logic                     locked,
  output logic [1:0]               state_o
);

  state_e state_r, state_nxt_s;

  logic [31:0]             phase_r, phase_nxt_s;
  logic                    parity_r, parity_nxt_s;
  logic [15:0]             good_cnt_r, bad_cnt_r, good_nxt_s, bad_nxt_s;
  logic                    strobe_r, strobe_nxt_s;
  logic [MU_W-1:0]         mu_r, mu_nxt_s;
  logic                    sym_r, sym_nxt_s;
  logic                    locked_r, locked_nxt_s;
  logic                    run_s, nco_en_s, ted_en_s, er_good_s;
  logic signed [ACC_W-1:0] nom_ext_s, ctrl_ext_s, step_wide_s;
  logic [31:0]             step_s, er_abs_s;
  logic [32:0]             sum_s;
  logic signed [CTRL_W-1:0] ctrl_s;

  // Dropping enable stops the NCO in the same cycle so no strobe leaks out on the way to IDLE.
  assign run_s    = enable && (state_r != ST_IDLE);
  assign nco_en_s = run_s && bus.sample_valid;
  assign ted_en_s = run_s && bus.ted_valid;

  timing_loop_filter #(
    .CTRL_MAX (CTRL_MAX)
  ) u_loop_filter (
    .clk      (clk),
    .reset    (reset),
    .clr      (!enable),
    .en       (ted_en_s),
    .er       (bus.ted_er),
    .kp_shift (cfg_kp_shift),
    .ki_shift (cfg_ki_shift),
    .ctrl     (ctrl_s)
  );

  // Corrected step, clamped so the NCO always advances and wraps at most once per sample.
  always_comb begin
    nom_ext_s   = $signed({2'b00, cfg_nom_step});
    ctrl_ext_s  = {{(ACC_W-CTRL_W){ctrl_s[CTRL_W-1]}}, ctrl_s};
    step_wide_s = nom_ext_s + ctrl_ext_s;
    if (step_wide_s < 34'sd1) begin
      step_s = 32'd1;
    end else if (step_wide_s > 34'sh0_FFFF_FFFF) begin
      step_s = 32'hFFFF_FFFF;
    end else begin
      step_s = step_wide_s[31:0];
    end
    sum_s = {1'b0, phase_r} + {1'b0, step_s};
  end

  // Error magnitude qualification and saturating good/bad run counters.
  always_comb begin
    if (bus.ted_er == 32'sh8000_0000) begin
      er_abs_s = 32'h7FFF_FFFF;
    end else if (bus.ted_er[CTRL_W-1]) begin
      er_abs_s = 32'(-bus.ted_er);
    end else begin
      er_abs_s = bus.ted_er;
    end
    er_good_s  = (er_abs_s < LOCK_THR);
    good_nxt_s = good_cnt_r;
    bad_nxt_s  = bad_cnt_r;
    if (!enable) begin
      good_nxt_s = 16'd0;
      bad_nxt_s  = 16'd0;
    end else if (ted_en_s && er_good_s) begin
      good_nxt_s = (good_cnt_r == 16'hFFFF) ? good_cnt_r : good_cnt_r + 16'd1;
      bad_nxt_s  = 16'd0;
    end else if (ted_en_s) begin
      good_nxt_s = 16'd0;
      bad_nxt_s  = (bad_cnt_r == 16'hFFFF) ? bad_cnt_r : bad_cnt_r + 16'd1;
    end else begin
      good_nxt_s = good_cnt_r;
      bad_nxt_s  = bad_cnt_r;
    end
  end

  // Next-state logic; lock decisions are taken on the TED sample that completes a run.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (enable) begin
          state_nxt_s = ST_ACQUIRE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACQUIRE: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (ted_en_s && (good_nxt_s >= 16'(LOCK_CNT))) begin
          state_nxt_s = ST_TRACK;
        end else begin
          state_nxt_s = ST_ACQUIRE;
        end
      end
      ST_TRACK: begin
        if (!enable) begin
          state_nxt_s = ST_IDLE;
        end else if (ted_en_s && (bad_nxt_s >= 16'(UNLOCK_CNT))) begin
          state_nxt_s = ST_ACQUIRE;
        end else begin
          state_nxt_s = ST_TRACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Strobe generation; parity_r=0 means the next strobe is the on-time one.
  always_comb begin
    phase_nxt_s  = phase_r;
    parity_nxt_s = parity_r;
    strobe_nxt_s = 1'b0;
    mu_nxt_s     = mu_r;
    sym_nxt_s    = sym_r;
    locked_nxt_s = (state_nxt_s == ST_TRACK);
    if (!enable) begin
      phase_nxt_s  = 32'd0;
      parity_nxt_s = 1'b0;
    end else if (nco_en_s && sum_s[32]) begin
      phase_nxt_s  = sum_s[31:0];
      strobe_nxt_s = 1'b1;
      mu_nxt_s     = sum_s[31 -: MU_W];
      sym_nxt_s    = ~parity_r;
      parity_nxt_s = ~parity_r;
    end else if (nco_en_s) begin
      phase_nxt_s  = sum_s[31:0];
    end else begin
      phase_nxt_s  = phase_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // NCO phase, parity, lock counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r    <= 32'd0;
      parity_r   <= 1'b0;
      good_cnt_r <= 16'd0;
      bad_cnt_r  <= 16'd0;
      strobe_r   <= 1'b0;
      mu_r       <= {MU_W{1'b0}};
      sym_r      <= 1'b0;
      locked_r   <= 1'b0;
    end else begin
      phase_r    <= phase_nxt_s;
      parity_r   <= parity_nxt_s;
      good_cnt_r <= good_nxt_s;
      bad_cnt_r  <= bad_nxt_s;
      strobe_r   <= strobe_nxt_s;
      mu_r       <= mu_nxt_s;
      sym_r      <= sym_nxt_s;
      locked_r   <= locked_nxt_s;
    end
  end

  assign bus.interp_strobe    = strobe_r;
  assign bus.interp_mu        = mu_r;
  assign bus.strobe_is_symbol = sym_r;
  assign loop_ctrl            = ctrl_s;
  assign locked               = locked_r;
  assign state_o              = state_r;

endmodule
